// File: rtl/wb_gpio_out.sv
// wb_gpio_out: Wishbone-controlled dual 32-bit GPIO output block with a blink engine.
//
// Ports:
//   clk, rst           - single clock, synchronous active-high reset
//   cyc_i, stb_i       - Wishbone cycle/strobe (block already selected by the decoder)
//   we_i, adr_i, sel_i - write enable, byte address (adr_i[5:2] decoded), byte lanes
//   dat_i / dat_o      - write data / registered read data
//   ack_o              - registered single-cycle acknowledge
//   gpio, gpio1        - output ports, driven straight from the OUT0/OUT1 flops
//
// Register map (word index adr_i[5:2]):
//   0 OUT0  1 SET0  2 CLR0  3 TGL0  4 OUT1  5 SET1  6 CLR1  7 TGL1
//   8 BLINK0  9 BLINK1  10 PERIOD  11 COUNT (RO)  12-15 unused

module wb_gpio_out #(
    parameter logic [31:0] RST_OUT0 = 32'h0000_0000,
    parameter logic [31:0] RST_OUT1 = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cyc_i,
    input  logic        stb_i,
    input  logic        we_i,
    input  logic [31:0] adr_i,
    input  logic [3:0]  sel_i,
    input  logic [31:0] dat_i,
    output logic [31:0] dat_o,
    output logic        ack_o,
    output logic [31:0] gpio,
    output logic [31:0] gpio1
);

    logic [31:0] out0_q, out0_d;
    logic [31:0] out1_q, out1_d;
    logic [31:0] blink0_q, blink0_d;
    logic [31:0] blink1_q, blink1_d;
    logic [31:0] period_q, period_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] dat_q, dat_d;
    logic        ack_q, ack_d;

    logic        req;
    logic        wr;
    logic        rd;
    logic [3:0]  idx;
    logic [31:0] mask;
    logic        period_wr;
    logic        cnt_wrap;
    logic        tick;
    logic [31:0] out0_bus;
    logic [31:0] out1_bus;

    // op: 0 = RW, 1 = SET, 2 = CLR, 3 = TGL
    function automatic logic [31:0] bus_update(input logic [31:0] cur, input logic [1:0] op,
                                               input logic [31:0] data, input logic [31:0] m);
        logic [31:0] res;
        res = cur;
        unique case (op)
            2'd0: res = (cur & ~m) | (data & m);
            2'd1: res = cur | (data & m);
            2'd2: res = cur & ~(data & m);
            2'd3: res = cur ^ (data & m);
            default: res = cur;
        endcase
        return res;
    endfunction

    always_comb begin
        req  = cyc_i & stb_i & ~ack_q;
        wr   = req & we_i;
        rd   = req & ~we_i;
        idx  = adr_i[5:2];
        mask = {{8{sel_i[3]}}, {8{sel_i[2]}}, {8{sel_i[1]}}, {8{sel_i[0]}}};

        // Blink counter; a PERIOD write restarts it and swallows this cycle's tick.
        period_wr = wr && (idx == 4'd10);
        cnt_wrap  = (period_q != 32'd0) && (cnt_q == period_q - 32'd1);
        tick      = cnt_wrap && !period_wr;
        if (period_wr || (period_q == 32'd0) || cnt_wrap) begin
            cnt_d = 32'd0;
        end else begin
            cnt_d = cnt_q + 32'd1;
        end

        out0_bus = out0_q;
        if (wr && (idx[3:2] == 2'b00)) begin
            out0_bus = bus_update(out0_q, idx[1:0], dat_i, mask);
        end
        out1_bus = out1_q;
        if (wr && (idx[3:2] == 2'b01)) begin
            out1_bus = bus_update(out1_q, idx[1:0], dat_i, mask);
        end

        // Pre-write blink masks apply, so a BLINKx write only affects later ticks.
        out0_d = tick ? (out0_bus ^ blink0_q) : out0_bus;
        out1_d = tick ? (out1_bus ^ blink1_q) : out1_bus;

        blink0_d = blink0_q;
        blink1_d = blink1_q;
        period_d = period_q;
        if (wr && (idx == 4'd8)) begin
            blink0_d = bus_update(blink0_q, 2'd0, dat_i, mask);
        end
        if (wr && (idx == 4'd9)) begin
            blink1_d = bus_update(blink1_q, 2'd0, dat_i, mask);
        end
        if (period_wr) begin
            period_d = bus_update(period_q, 2'd0, dat_i, mask);
        end

        dat_d = dat_q;
        if (rd) begin
            unique case (idx)
                4'd0:    dat_d = out0_q;
                4'd4:    dat_d = out1_q;
                4'd8:    dat_d = blink0_q;
                4'd9:    dat_d = blink1_q;
                4'd10:   dat_d = period_q;
                4'd11:   dat_d = cnt_q;
                default: dat_d = 32'd0;
            endcase
        end

        ack_d = req;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out0_q   <= RST_OUT0;
            out1_q   <= RST_OUT1;
            blink0_q <= 32'd0;
            blink1_q <= 32'd0;
            period_q <= 32'd0;
            cnt_q    <= 32'd0;
            dat_q    <= 32'd0;
            ack_q    <= 1'b0;
        end else begin
            out0_q   <= out0_d;
            out1_q   <= out1_d;
            blink0_q <= blink0_d;
            blink1_q <= blink1_d;
            period_q <= period_d;
            cnt_q    <= cnt_d;
            dat_q    <= dat_d;
            ack_q    <= ack_d;
        end
    end

    assign dat_o = dat_q;
    assign ack_o = ack_q;
    assign gpio  = out0_q;
    assign gpio1 = out1_q;

endmodule

// File: tb/tb_wb_gpio_out.sv
// tb_wb_gpio_out: directed self-checking bench for wb_gpio_out.
// Inputs change on the falling edge; outputs are sampled on the falling edge.

module tb_wb_gpio_out;

    logic        clk;
    logic        rst;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat_w;
    logic [31:0] dat_r;
    logic        ack;
    logic [31:0] gpio;
    logic [31:0] gpio1;

    int unsigned n_total;
    int unsigned n_pass;

    logic        last_ack;
    logic [31:0] last_gpio;
    logic [31:0] last_gpio1;
    logic [31:0] rdata;
    logic [31:0] snap0;
    logic [31:0] snap1;
    int unsigned acks;

    wb_gpio_out dut (
        .clk   (clk),
        .rst   (rst),
        .cyc_i (cyc),
        .stb_i (stb),
        .we_i  (we),
        .adr_i (adr),
        .sel_i (sel),
        .dat_i (dat_w),
        .dat_o (dat_r),
        .ack_o (ack),
        .gpio  (gpio),
        .gpio1 (gpio1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    endtask

    // Request edge is the first rising edge after the drive; the sample falls in the ack cycle.
    task automatic wb_access(input logic w, input logic [3:0] idx, input logic [31:0] d,
                             input logic [3:0] s);
        @(negedge clk);
        cyc   = 1'b1;
        stb   = 1'b1;
        we    = w;
        adr   = {24'hABCDEF, 2'b00, idx, 2'b00};
        sel   = s;
        dat_w = d;
        @(negedge clk);
        last_ack   = ack;
        last_gpio  = gpio;
        last_gpio1 = gpio1;
        rdata      = dat_r;
        cyc = 1'b0;
        stb = 1'b0;
        we  = 1'b0;
    endtask

    task automatic wb_write(input logic [3:0] idx, input logic [31:0] d, input logic [3:0] s);
        wb_access(1'b1, idx, d, s);
    endtask

    task automatic wb_read(input logic [3:0] idx);
        wb_access(1'b0, idx, 32'hDEAD_BEEF, 4'hF);
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        rst   = 1'b1;
        cyc   = 1'b1;
        stb   = 1'b1;
        we    = 1'b0;
        adr   = 32'd0;
        sel   = 4'hF;
        dat_w = 32'd0;

        // Reset held for 10 cycles with a request pending: it must never be acked.
        repeat (10) @(negedge clk);
        check("reset_ack_dropped", {31'd0, ack}, 32'd0);
        cyc = 1'b0;
        stb = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("reset_gpio", gpio, 32'h0);
        check("reset_gpio1", gpio1, 32'h0);
        check("reset_ack", {31'd0, ack}, 32'd0);
        wb_read(4'd10);
        check("reset_period", rdata, 32'h0);

        // Byte lanes.
        wb_write(4'd0, 32'hFFFF_FFFF, 4'hF);
        wb_write(4'd0, 32'hA5A5_A5A5, 4'b0011);
        check("lanes_gpio_at_ack", last_gpio, 32'hFFFF_A5A5);
        check("lanes_ack_high", {31'd0, last_ack}, 32'd1);
        @(negedge clk);
        check("lanes_ack_one_cycle", {31'd0, ack}, 32'd0);
        wb_read(4'd0);
        check("lanes_readback", rdata, 32'hFFFF_A5A5);

        // Set / clear / toggle on port 1.
        wb_write(4'd4, 32'h0F0F_0000, 4'hF);
        wb_write(4'd5, 32'h0000_00FF, 4'hF);
        check("set1", last_gpio1, 32'h0F0F_00FF);
        wb_write(4'd6, 32'h0F00_0000, 4'hF);
        check("clr1", last_gpio1, 32'h000F_00FF);
        wb_write(4'd7, 32'h0000_00F0, 4'hF);
        check("tgl1", last_gpio1, 32'h000F_000F);
        wb_read(4'd5);
        check("read_set1_zero", rdata, 32'h0);
        check("gpio0_untouched", gpio, 32'hFFFF_A5A5);

        // Blink with PERIOD = 4: first tick 4 edges after the PERIOD write,
        // OUT0 written 2 edges after it, so sample k sees parity((k+2)/4).
        wb_write(4'd8, 32'h0000_0001, 4'hF);
        wb_write(4'd10, 32'd4, 4'hF);
        wb_write(4'd0, 32'h0, 4'hF);
        check("blink_start", last_gpio, 32'h0);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) check("blink_k1", gpio, 32'h0);
            if (k == 2) check("blink_k2", gpio, 32'h1);
            if (k == 5) check("blink_k5", gpio, 32'h1);
            if (k == 6) check("blink_k6", gpio, 32'h0);
            if (k == 10) check("blink_k10", gpio, 32'h1);
        end
        wb_read(4'd11);
        check("count_in_range", {31'd0, (rdata < 32'd4)}, 32'd1);
        wb_write(4'd10, 32'd0, 4'hF);
        snap0 = gpio;
        repeat (8) @(negedge clk);
        check("blink_frozen", gpio, snap0);
        wb_read(4'd11);
        check("count_zero", rdata, 32'h0);

        // Collision of a bus write with a tick: PERIOD = 1 ticks every cycle.
        wb_write(4'd10, 32'd1, 4'hF);
        wb_write(4'd8, 32'h0000_0003, 4'hF);
        wb_write(4'd0, 32'h0000_0010, 4'hF);
        check("collide_ack_cycle", last_gpio, 32'h0000_0013);
        @(negedge clk);
        check("collide_next", gpio, 32'h0000_0010);
        wb_write(4'd10, 32'd0, 4'hF);
        wb_write(4'd8, 32'd0, 4'hF);

        // Unused index 13 and read-only COUNT: acked, nothing changes.
        snap0 = gpio;
        snap1 = gpio1;
        wb_write(4'd13, 32'hFFFF_FFFF, 4'hF);
        check("illegal_ack", {31'd0, last_ack}, 32'd1);
        check("illegal_gpio", gpio, snap0);
        check("illegal_gpio1", gpio1, snap1);
        wb_write(4'd11, 32'h1234_5678, 4'hF);
        wb_read(4'd11);
        check("count_write_ignored", rdata, 32'h0);
        wb_read(4'd8);
        check("blink0_unchanged", rdata, 32'h0);

        // Strobe held for 6 cycles yields 3 acks.
        @(negedge clk);
        cyc  = 1'b1;
        stb  = 1'b1;
        we   = 1'b0;
        adr  = 32'd0;
        acks = 0;
        repeat (6) begin
            @(negedge clk);
            if (ack) acks++;
        end
        cyc = 1'b0;
        stb = 1'b0;
        check("b2b_acks", acks, 32'd3);
        check("b2b_data", dat_r, snap0);

        // Reset mid-blink with a write pending: write dropped, blinking stops.
        wb_write(4'd8, 32'h0000_0001, 4'hF);
        wb_write(4'd10, 32'd1, 4'hF);
        @(negedge clk);
        rst   = 1'b1;
        cyc   = 1'b1;
        stb   = 1'b1;
        we    = 1'b1;
        adr   = 32'd0;
        dat_w = 32'h0000_00FF;
        @(negedge clk);
        check("rst_mid_ack", {31'd0, ack}, 32'd0);
        check("rst_mid_gpio", gpio, 32'h0);
        rst = 1'b0;
        cyc = 1'b0;
        stb = 1'b0;
        we  = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_blink_stopped", gpio, 32'h0);
        wb_read(4'd10);
        check("rst_period_cleared", rdata, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/wb_gpio_out.md
WB_GPIO_OUT -- requirements
Module: wb_gpio_out

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- RST_OUT0, 32'h0000_0000, reset value of gpio.
- RST_OUT1, 32'h0000_0000, reset value of gpio1.

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all state updates on its rising edge.
- rst, in, 1, synchronous active-high reset.
- cyc_i, in, 1, Wishbone cycle.
- stb_i, in, 1, Wishbone strobe; the block is already selected by the SoC decoder.
- we_i, in, 1, write enable.
- adr_i, in, 32, byte address; only adr_i[5:2] is decoded.
- sel_i, in, 4, byte-lane enables.
- dat_i, in, 32, write data.
- dat_o, out, 32, registered read data.
- ack_o, out, 1, registered single-cycle acknowledge.
- gpio, out, 32, output port 0 (OUT0 register).
- gpio1, out, 32, output port 1 (OUT1 register).

Function
REQ-003 The register map SHALL use adr_i[5:2] word indices:
- 0 OUT0 RW; 1 SET0 W; 2 CLR0 W; 3 TGL0 W.
- 4 OUT1 RW; 5 SET1 W; 6 CLR1 W; 7 TGL1 W.
- 8 BLINK0 RW; 9 BLINK1 RW; 10 PERIOD RW; 11 COUNT RO.

REQ-004 Handshake: ack_o SHALL be 1 in the cycle after the request edge:
- a request edge is any rising edge with cyc_i&stb_i&!ack_o;
- ack_o is high for exactly one cycle per request;
- back-to-back held strobes yield an ack every second cycle.

REQ-005 A write SHALL take effect at the request edge, so the new value is visible on gpio/gpio1 in the same cycle ack_o is high.

REQ-006 Byte lanes: a write byte mask SHALL be M = {8{sel_i[3]},8{sel_i[2]},8{sel_i[1]},8{sel_i[0]}}, applied to every writable register.
- RW: reg = (reg & ~M) | (dat_i & M).
- SET: reg |= dat_i & M.
- CLR: reg &= ~(dat_i & M).
- TGL: reg ^= dat_i & M.

REQ-007 Reads SHALL load dat_o at the request edge:
- RW registers return their current value;
- SET/CLR/TGL and indices 12-15 return 0;
- COUNT returns the blink counter.
- dat_o is held between reads.

REQ-008 Writes to COUNT and to indices 12-15 SHALL be acknowledged and ignored.

REQ-009 Blink engine:
- A 32-bit counter CNT runs when PERIOD != 0.
- CNT increments each cycle; when CNT == PERIOD-1, CNT returns to 0 and tick = 1 for that cycle.
- PERIOD == 0 holds CNT at 0 with tick = 0.
- PERIOD = 1 produces a tick every cycle.

REQ-010 On a tick, OUT0 ^= BLINK0 and OUT1 ^= BLINK1.

REQ-011 Simultaneous bus write and tick on the same port SHALL resolve as next = busresult ^ BLINKx.
- busresult is the REQ-006 result computed from the current register value.
- BLINKx is the pre-write mask.

REQ-012 Any write to PERIOD SHALL clear CNT to 0 and suppress the tick in that cycle.

REQ-013 Writes to BLINKx SHALL take effect for ticks from the next cycle onward.

REQ-014 gpio and gpio1 SHALL be driven directly from the OUT0 and OUT1 flops, with no combinational path from the bus.

Reset
REQ-015 While rst = 1 at a rising edge, the block SHALL load:
- OUT0 = RST_OUT0, OUT1 = RST_OUT1;
- BLINK0 = BLINK1 = 0, PERIOD = 0, CNT = 0;
- ack_o = 0, dat_o = 0.

REQ-016 Reset SHALL override any request or tick in the same cycle; a request pending at reset SHALL be dropped, not acknowledged.

REQ-017 Reset asserted mid-blink SHALL stop blinking until PERIOD is rewritten.

Verification
REQ-018 The bench SHALL cover the following directed scenarios (stimulus -> required response).
- Reset: hold rst for 10 cycles, then release -> gpio = 0, gpio1 = 0, ack_o = 0, read PERIOD = 0.
- Lanes: write OUT0 = 0xA5A5A5A5 with sel = 4'b0011 over 0xFFFFFFFF -> gpio = 0xFFFFA5A5; ack_o high exactly 1 cycle.
- Set/clear/toggle: OUT1 = 0x0F0F0000, SET1 0x000000FF, CLR1 0x0F000000, TGL1 0x000000F0 -> gpio1 = 0x000F000F; reading SET1 returns 0.
- Blink: BLINK0 = 0x1, PERIOD = 4, OUT0 = 0 -> gpio[0] toggles every 4 cycles; COUNT reads within 0..3; PERIOD = 0 freezes gpio[0] and COUNT = 0.
- Collision: PERIOD = 1, BLINK0 = 0x3, then write OUT0 = 0x10 -> gpio = 0x13 at the ack cycle, 0x10 next cycle.
- Illegal and back-to-back: write index 13 -> acked, no state change; stb held for 6 cycles -> 3 acks.
